// File: rtl/psram_burst_arb.sv
// psram_burst_arb
//   Arbitrates between one write-burst and one read-burst requester and
//   drives the PSRAM IP command interface. Bursts are BURST_BEATS words long.
//   After each burst a fixed gap of TCMD_GAP idle cycles is enforced.
//
// Ports
//   I_dma_clk, I_rst_n          : single clock, async active-low reset
//   init_done                   : PSRAM calibrated; arbitration only when high
//   I_wr_req/I_wr_addr/O_wr_gnt : write-burst request handshake
//   I_wr_data/O_wr_data_rd      : FWFT write FIFO data and pop (one per beat)
//   I_rd_req/I_rd_addr/O_rd_gnt : read-burst request handshake
//   O_rd_data/O_rd_data_vld     : read beats forwarded toward the read FIFO
//   O_wr_done/O_rd_done         : one-cycle burst-complete pulses
//   cmd/cmd_en/addr/wr_data/data_mask : PSRAM IP command side (cmd 1=write)
//   rd_data_valid/rd_data       : PSRAM IP read return
//   O_busy/O_rd_timeout         : burst in progress / sticky read timeout
module psram_burst_arb #(
   parameter int ADDR_WIDTH  = 21,
   parameter int DATA_WIDTH  = 64,
   parameter int BURST_BEATS = 32,
   parameter int TCMD_GAP    = 4,
   parameter int RD_TIMEOUT  = 255
) (
   input  logic                    I_dma_clk,
   input  logic                    I_rst_n,
   input  logic                    init_done,
   input  logic                    I_wr_req,
   input  logic [ADDR_WIDTH-1:0]   I_wr_addr,
   output logic                    O_wr_gnt,
   input  logic [DATA_WIDTH-1:0]   I_wr_data,
   output logic                    O_wr_data_rd,
   input  logic                    I_rd_req,
   input  logic [ADDR_WIDTH-1:0]   I_rd_addr,
   output logic                    O_rd_gnt,
   output logic [DATA_WIDTH-1:0]   O_rd_data,
   output logic                    O_rd_data_vld,
   output logic                    O_wr_done,
   output logic                    O_rd_done,
   output logic                    cmd,
   output logic                    cmd_en,
   output logic [ADDR_WIDTH-1:0]   addr,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic [DATA_WIDTH/8-1:0] data_mask,
   input  logic                    rd_data_valid,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    O_busy,
   output logic                    O_rd_timeout
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_CMD  = 3'd1;
   localparam logic [2:0] S_WR_DATA = 3'd2;
   localparam logic [2:0] S_RD_CMD  = 3'd3;
   localparam logic [2:0] S_RD_WAIT = 3'd4;
   localparam logic [2:0] S_GAP     = 3'd5;

   localparam int BW = $clog2(BURST_BEATS + 1);
   localparam int TW = $clog2(RD_TIMEOUT + 1);
   localparam int GW = 4;

   logic [2:0]            state, state_nx;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  last_rd;   // previous granted burst was a read
   logic [BW-1:0]         beat_cnt;
   logic [TW-1:0]         tmo_cnt;
   logic [GW-1:0]         gap_cnt;
   logic                  rd_tmo_q;

   logic arb_en, pick_rd, wr_last, rd_beat, rd_last, rd_expire;

   // Grants are combinational in IDLE; gating with I_rst_n keeps them quiet
   // while reset is held even if init_done and requests are already high.
   assign arb_en    = (state == S_IDLE) && init_done && I_rst_n;
   assign pick_rd   = I_rd_req && (!I_wr_req || !last_rd);
   assign O_rd_gnt  = arb_en && pick_rd;
   assign O_wr_gnt  = arb_en && I_wr_req && !pick_rd;

   // Write beat 0 is issued in WR_CMD, so WR_DATA ends at count BURST_BEATS-1.
   assign wr_last   = (state == S_WR_DATA) && (beat_cnt == BW'(BURST_BEATS - 1));
   assign rd_beat   = (state == S_RD_WAIT) && rd_data_valid;
   assign rd_last   = rd_beat && (beat_cnt == BW'(BURST_BEATS - 1));
   // A final beat landing on the timeout cycle still completes normally.
   assign rd_expire = (state == S_RD_WAIT) && !rd_last && (tmo_cnt == TW'(RD_TIMEOUT));

   assign cmd_en        = (state == S_WR_CMD) || (state == S_RD_CMD);
   assign cmd           = (state == S_WR_CMD);
   assign addr          = cmd_en ? addr_q : '0;
   assign O_wr_data_rd  = (state == S_WR_CMD) || (state == S_WR_DATA);
   assign wr_data       = O_wr_data_rd ? I_wr_data : '0;
   assign O_wr_done     = wr_last;
   assign O_rd_data_vld = rd_beat;
   assign O_rd_data     = rd_beat ? rd_data : '0;
   assign O_rd_done     = rd_last;
   assign data_mask     = '0;
   assign O_busy        = (state != S_IDLE);
   assign O_rd_timeout  = rd_tmo_q;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (O_rd_gnt) state_nx = S_RD_CMD;
                    else if (O_wr_gnt) state_nx = S_WR_CMD;
         S_WR_CMD:  state_nx = S_WR_DATA;
         S_WR_DATA: if (wr_last) state_nx = S_GAP;
         S_RD_CMD:  state_nx = S_RD_WAIT;
         S_RD_WAIT: if (rd_last || rd_expire) state_nx = S_GAP;
         S_GAP:     if (gap_cnt == GW'(TCMD_GAP - 1)) state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         last_rd  <= 1'b0;
         beat_cnt <= '0;
         tmo_cnt  <= '0;
         gap_cnt  <= '0;
         rd_tmo_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (O_rd_gnt) begin
            addr_q  <= I_rd_addr;
            last_rd <= 1'b1;
         end else if (O_wr_gnt) begin
            addr_q  <= I_wr_addr;
            last_rd <= 1'b0;
         end
         case (state)
            S_WR_CMD:  beat_cnt <= BW'(1);
            S_WR_DATA: beat_cnt <= beat_cnt + BW'(1);
            S_RD_CMD: begin
               // The RD_CMD cycle itself counts toward the timeout.
               beat_cnt <= '0;
               tmo_cnt  <= TW'(1);
            end
            S_RD_WAIT: begin
               if (rd_beat) beat_cnt <= beat_cnt + BW'(1);
               if (tmo_cnt != TW'(RD_TIMEOUT)) tmo_cnt <= tmo_cnt + TW'(1);
               if (rd_expire) rd_tmo_q <= 1'b1;
            end
            S_GAP:     gap_cnt <= (state_nx == S_IDLE) ? '0 : gap_cnt + GW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_psram_burst_arb.sv
// tb_psram_burst_arb
//   Directed sequence with randomized addresses, data and read-return holes.
//   Expected behaviour comes from a small model: a write FIFO queue, the
//   arbitration rule on the driven requests, beat counting of the returned
//   read data, and the cycle distances the block must honour.
module tb_psram_burst_arb;
   localparam int AW    = 21;
   localparam int DW    = 64;
   localparam int BEATS = 32;
   localparam int GAP   = 4;
   localparam int TMO   = 255;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, init_done, wr_req, rd_req, rd_data_valid;
   logic [AW-1:0] wr_addr, rd_addr, addr;
   logic [DW-1:0] wr_data_in, rd_data_in, rd_data_o, wr_data_o;
   logic          wr_gnt, rd_gnt, wr_data_rd, rd_vld, wr_done, rd_done;
   logic          cmd, cmd_en, busy, rd_tmo;
   logic [DW/8-1:0] dmask;

   psram_burst_arb #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_BEATS(BEATS),
      .TCMD_GAP(GAP), .RD_TIMEOUT(TMO)
   ) dut (
      .I_dma_clk(clk), .I_rst_n(rst_n), .init_done(init_done),
      .I_wr_req(wr_req), .I_wr_addr(wr_addr), .O_wr_gnt(wr_gnt),
      .I_wr_data(wr_data_in), .O_wr_data_rd(wr_data_rd),
      .I_rd_req(rd_req), .I_rd_addr(rd_addr), .O_rd_gnt(rd_gnt),
      .O_rd_data(rd_data_o), .O_rd_data_vld(rd_vld),
      .O_wr_done(wr_done), .O_rd_done(rd_done),
      .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data_o),
      .data_mask(dmask), .rd_data_valid(rd_data_valid), .rd_data(rd_data_in),
      .O_busy(busy), .O_rd_timeout(rd_tmo)
   );

   int n_run = 0, n_fail = 0;
   int cyc = 0, n_cmd = 0, n_gnt = 0, n_pop = 0, mask_bad = 0, idle_cmd_bad = 0;
   logic          last_rd_m;      // model: previous granted burst was a read
   logic [DW-1:0] wq[$];          // model of the write FIFO contents

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (cmd_en) n_cmd <= n_cmd + 1;
      if (wr_gnt | rd_gnt) n_gnt <= n_gnt + 1;
      if (wr_data_rd) n_pop <= n_pop + 1;
      if (dmask !== '0) mask_bad <= mask_bad + 1;
      if (cmd_en && !busy) idle_cmd_bad <= idle_cmd_bad + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic wq_pop();
      void'(wq.pop_front());
      if (wq.size() == 0) wq.push_back({$urandom, $urandom});
      wr_data_in = wq[0];
   endtask

   // Returns at the negedge of the grant cycle (or after maxc cycles).
   task automatic grant_step(input int maxc, output logic is_rd, output int waited, output int gcyc);
      logic gw, gr, exp_rd;
      gw = 1'b0; gr = 1'b0; waited = maxc;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (wr_gnt || rd_gnt) begin
            gw = wr_gnt; gr = rd_gnt; waited = i;
            break;
         end
         to_pos();
      end
      gcyc   = cyc;
      exp_rd = rd_req && (!wr_req || !last_rd_m);
      chk("grant_seen", 64'(gw | gr), 64'(1));
      chk("grant_is_rd", 64'(gr), 64'(exp_rd));
      chk("grant_onehot", 64'(gw & gr), 64'(0));
      if (gw | gr) last_rd_m = gr;
      is_rd = gr;
   endtask

   // Entry: just after the edge that starts WR_CMD. abort_at >= 0 pulls reset
   // mid-cycle of that beat and checks the outputs drop at once.
   task automatic do_write(input logic [AW-1:0] a, input int abort_at, output int done_cyc);
      int bad = 0, pops = 0, dones = 0, cmds = 0, done_at = -1;
      logic popped;
      done_cyc = -1;
      for (int c = 0; c < BEATS + 1; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("wr_cmd_en", 64'(cmd_en), 64'(1));
            chk("wr_cmd", 64'(cmd), 64'(1));
            chk("wr_addr", 64'(addr), 64'(a));
         end
         popped = wr_data_rd;
         if (wr_data_rd) begin
            pops++;
            if (c >= BEATS) bad++;
            if (wr_data_o !== wq[0]) bad++;
         end else if (c < BEATS) bad++;
         if (cmd_en) cmds++;
         if (wr_done) begin dones++; done_at = c; done_cyc = cyc; end
         if (c == abort_at) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_mid_pop", 64'(wr_data_rd), 64'(0));
            chk("rst_mid_cmd_en", 64'(cmd_en), 64'(0));
            chk("rst_mid_busy", 64'(busy), 64'(0));
            return;
         end
         to_pos();
         if (popped) wq_pop();
      end
      chk("wr_pops", 64'(pops), 64'(BEATS));
      chk("wr_beat_err", 64'(bad), 64'(0));
      chk("wr_cmds", 64'(cmds), 64'(1));
      chk("wr_done_cnt", 64'(dones), 64'(1));
      chk("wr_done_beat", 64'(done_at), 64'(BEATS - 1));
   endtask

   // Entry: just after the edge that starts RD_CMD. hole<0 gives random holes.
   task automatic do_read(input logic [AW-1:0] a, input int nret, input int hole,
                          input logic exp_done, output int done_cyc);
      int bad = 0, sent = 0, dones = 0, tmo_c = -1, gap_left = 0;
      logic stop = 1'b0;
      done_cyc = -1;
      rd_data_valid = 1'b1;                     // stray beat during RD_CMD
      rd_data_in = {$urandom, $urandom};
      @(negedge clk);
      chk("rd_cmd_en", 64'(cmd_en), 64'(1));
      chk("rd_cmd", 64'(cmd), 64'(0));
      chk("rd_addr", 64'(addr), 64'(a));
      chk("rd_stray_vld", 64'(rd_vld), 64'(0));
      to_pos();
      for (int c = 1; c < TMO + 10 && !stop; c++) begin
         if (sent < nret && gap_left == 0) begin
            rd_data_valid = 1'b1;
            rd_data_in = {$urandom, $urandom};
            sent++;
            gap_left = (hole < 0) ? int'($urandom_range(0, 3)) : hole;
         end else begin
            rd_data_valid = 1'b0;
            if (gap_left > 0) gap_left--;
         end
         @(negedge clk);
         if (rd_vld !== rd_data_valid) bad++;
         if (rd_data_valid && rd_data_o !== rd_data_in) bad++;
         if (rd_done) begin
            dones++; done_cyc = cyc; stop = 1'b1;
            if (!(rd_data_valid && sent == BEATS)) bad++;
         end
         if (!exp_done && rd_tmo && tmo_c < 0) begin tmo_c = c; stop = 1'b1; end
         to_pos();
      end
      rd_data_valid = 1'b0;
      chk("rd_beat_err", 64'(bad), 64'(0));
      if (exp_done) chk("rd_done_cnt", 64'(dones), 64'(1));
      else begin
         chk("rd_no_done", 64'(dones), 64'(0));
         chk("rd_tmo_window", 64'(tmo_c >= TMO && tmo_c <= TMO + 1), 64'(1));
      end
   endtask

   initial begin
      logic is_rd;
      int w, gc, dc, s_cmd, s_gnt, s_pop;
      logic [AW-1:0] a, a2;

      rst_n = 1'b0; init_done = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      wr_addr = 21'h00100; rd_addr = 21'h1FFF00;
      rd_data_valid = 1'b0; rd_data_in = '0;
      wq.push_back({$urandom, $urandom});
      wr_data_in = wq[0];
      last_rd_m = 1'b0;

      // Reset held with requests and init_done high
      repeat (3) to_pos();
      @(negedge clk);
      chk("rst_gnt", 64'({wr_gnt, rd_gnt}), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_cmd_en", 64'(cmd_en), 64'(0));
      chk("rst_pop", 64'(wr_data_rd), 64'(0));
      chk("rst_addr", 64'(addr), 64'(0));
      chk("rst_tmo", 64'(rd_tmo), 64'(0));
      to_pos();
      init_done = 1'b0;
      rst_n = 1'b1;

      // No arbitration without init_done
      s_cmd = n_cmd; s_gnt = n_gnt;
      repeat (100) to_pos();
      chk("noinit_gnt", 64'(n_gnt - s_gnt), 64'(0));
      chk("noinit_cmd", 64'(n_cmd - s_cmd), 64'(0));
      init_done = 1'b1;
      grant_step(4, is_rd, w, gc);
      chk("init_gnt_lat", 64'(w <= 1), 64'(1));
      to_pos(); rd_req = 1'b0;
      do_read(21'h1FFF00, BEATS, -1, 1'b1, dc);

      // Write at 0x00100; address changes after grant must not matter
      grant_step(20, is_rd, w, gc);
      to_pos();
      wr_req = 1'b0; wr_addr = AW'($urandom);
      rd_addr = 21'h1FFF00; rd_req = 1'b1;
      do_write(21'h00100, -1, dc);
      grant_step(20, is_rd, w, gc);
      chk("gap_len", 64'(gc - dc), 64'(GAP + 1));
      to_pos(); rd_req = 1'b0;
      do_read(21'h1FFF00, BEATS, 2, 1'b1, dc);

      // Request withdrawn during GAP: nothing happens
      s_cmd = n_cmd; s_gnt = n_gnt;
      wr_req = 1'b1; to_pos(); wr_req = 1'b0;
      repeat (12) to_pos();
      chk("withdraw_gnt", 64'(n_gnt - s_gnt), 64'(0));
      chk("withdraw_cmd", 64'(n_cmd - s_cmd), 64'(0));

      // Both requests held: bursts alternate
      for (int k = 0; k < 8; k++) begin
         wr_addr = AW'($urandom); rd_addr = AW'($urandom);
         wr_req = 1'b1; rd_req = 1'b1;
         grant_step(20, is_rd, w, gc);
         a = is_rd ? rd_addr : wr_addr;
         to_pos();
         if (is_rd) do_read(a, BEATS, -1, 1'b1, dc);
         else do_write(a, -1, dc);
      end
      wr_req = 1'b0; rd_req = 1'b0;

      // Short read return times out; pending write served afterwards
      rd_addr = AW'($urandom); rd_req = 1'b1; a = rd_addr;
      grant_step(20, is_rd, w, gc);
      to_pos();
      rd_req = 1'b0; wr_addr = AW'($urandom); a2 = wr_addr; wr_req = 1'b1;
      do_read(a, 10, -1, 1'b0, dc);
      grant_step(20, is_rd, w, gc);
      to_pos(); wr_req = 1'b0;
      do_write(a2, -1, dc);
      chk("tmo_sticky", 64'(rd_tmo), 64'(1));

      // Reset during beat 12 of a write
      wr_addr = AW'($urandom); a = wr_addr; wr_req = 1'b1;
      grant_step(20, is_rd, w, gc);
      to_pos(); wr_req = 1'b0;
      do_write(a, 12, dc);
      last_rd_m = 1'b0;
      to_pos(); to_pos();
      @(negedge clk);
      chk("rst_tmo_clr", 64'(rd_tmo), 64'(0));
      chk("rst_hold_busy", 64'(busy), 64'(0));
      to_pos(); rst_n = 1'b1;
      s_cmd = n_cmd; s_pop = n_pop;
      repeat (6) to_pos();
      chk("post_rst_cmd", 64'(n_cmd - s_cmd), 64'(0));
      chk("post_rst_pop", 64'(n_pop - s_pop), 64'(0));
      wr_addr = AW'($urandom); a2 = wr_addr;
      rd_addr = AW'($urandom); a = rd_addr;
      wr_req = 1'b1; rd_req = 1'b1;
      grant_step(20, is_rd, w, gc);
      to_pos(); rd_req = 1'b0;
      do_read(a, BEATS, -1, 1'b1, dc);
      grant_step(20, is_rd, w, gc);
      to_pos(); wr_req = 1'b0;
      do_write(a2, -1, dc);

      repeat (6) to_pos();
      chk("data_mask_zero", 64'(mask_bad), 64'(0));
      chk("cmd_en_only_busy", 64'(idle_cmd_bad), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
